// File: rtl/pe_dual_mode.sv
// pe_dual_mode: systolic-array processing element with selectable dataflow.
// The processing element supports two dataflows:
//   WS (mode=0): partial sums pass through, c_out = sat(a*w + c_in).
//   OS (mode=1): products accumulate locally; acc_load drains acc into the
//                vertical result chain, which otherwise shifts c_in south.
// Operands are signed or unsigned at runtime (signed_en). Sums can clamp
// (SATURATE=1) or wrap (SATURATE=0). Either way, overflow sets a sticky ovf.
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   mode, signed_en                        quasi-static configuration
//   a_in/a_valid_in/a_clear_in             activation from west
//   a_out/a_valid_out/a_clear_out          registered copies to east
//   b_path_in/b_path_en_in/b_en_in         weight chain from north
//   b_path_out/b_path_en_out/b_en_out      weight chain to south
//   c_in/c_valid_in, acc_load              partial sum / drain data from north
//   c_out/c_valid_out                      result to south
//   ovf                                    sticky overflow flag
module pe_dual_mode #(
    parameter int unsigned INP_DATA_WIDTH = 8,
    parameter int unsigned WGT_DATA_WIDTH = 8,
    parameter int unsigned ARRAY_N        = 16,
    parameter int unsigned PE_OUT_WIDTH   = INP_DATA_WIDTH + WGT_DATA_WIDTH + $clog2(ARRAY_N),
    parameter int unsigned SATURATE       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic                      signed_en,
    input  logic [INP_DATA_WIDTH-1:0] a_in,
    input  logic                      a_valid_in,
    input  logic                      a_clear_in,
    output logic [INP_DATA_WIDTH-1:0] a_out,
    output logic                      a_valid_out,
    output logic                      a_clear_out,
    input  logic [WGT_DATA_WIDTH-1:0] b_path_in,
    input  logic                      b_path_en_in,
    input  logic                      b_en_in,
    output logic [WGT_DATA_WIDTH-1:0] b_path_out,
    output logic                      b_path_en_out,
    output logic                      b_en_out,
    input  logic [PE_OUT_WIDTH-1:0]   c_in,
    input  logic                      c_valid_in,
    input  logic                      acc_load,
    output logic [PE_OUT_WIDTH-1:0]   c_out,
    output logic                      c_valid_out,
    output logic                      ovf
);

    localparam int unsigned W  = PE_OUT_WIDTH;
    localparam int unsigned AW = INP_DATA_WIDTH;
    localparam int unsigned BW = WGT_DATA_WIDTH;

    logic [BW-1:0] active_w;
    logic [W-1:0]  prod;
    logic          prod_valid;
    logic          prod_clear;
    logic [W-1:0]  acc;

    logic [W-1:0]  a_ext;
    logic [W-1:0]  w_ext;
    logic [W:0]    ws_res;
    logic [W:0]    os_res;

    // Adds x + y at W+1 bits. Returns {overflow, result}. On overflow the
    // result is clamped when SATURATE is set and wrapped otherwise.
    function automatic logic [W:0] sat_add(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic         sgn);
        logic [W:0]   sum;
        logic         ov;
        logic [W-1:0] res;
        if (sgn) begin
            sum = {x[W-1], x} + {y[W-1], y};
            ov  = sum[W] ^ sum[W-1];
        end else begin
            sum = {1'b0, x} + {1'b0, y};
            ov  = sum[W];
        end
        res = sum[W-1:0];
        if (ov && (SATURATE != 0)) begin
            if (sgn) begin
                res = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end else begin
                res = '1;
            end
        end
        return {ov, res};
    endfunction

    // Extend the operands to the accumulator width. The low W bits of the
    // product are then correct for both signed and unsigned operands.
    always_comb begin
        a_ext  = signed_en ? {{(W-AW){a_out[AW-1]}}, a_out}
                           : {{(W-AW){1'b0}}, a_out};
        w_ext  = signed_en ? {{(W-BW){active_w[BW-1]}}, active_w}
                           : {{(W-BW){1'b0}}, active_w};
        ws_res = sat_add(prod, c_in, signed_en);
        os_res = sat_add(acc, prod, signed_en);
    end

    // Horizontal pass-through and weight double buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out         <= '0;
            a_valid_out   <= 1'b0;
            a_clear_out   <= 1'b0;
            b_path_out    <= '0;
            b_path_en_out <= 1'b0;
            b_en_out      <= 1'b0;
            active_w      <= '0;
        end else begin
            a_out         <= a_in;
            a_valid_out   <= a_valid_in;
            a_clear_out   <= a_clear_in;
            b_path_en_out <= b_path_en_in;
            b_en_out      <= b_en_in;
            if (b_path_en_in) b_path_out <= b_path_in;
            // If both enables are high, active takes the pre-edge shadow.
            if (b_en_in)      active_w   <= b_path_out;
        end
    end

    // Multiply stage
    always_ff @(posedge clk) begin
        if (rst) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            prod_clear <= 1'b0;
        end else begin
            prod       <= a_ext * w_ext;
            prod_valid <= a_valid_out;
            prod_clear <= a_clear_out;
        end
    end

    // Add stage: WS pass-through sum, or OS accumulate plus drain shift
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            c_out       <= '0;
            c_valid_out <= 1'b0;
            ovf         <= 1'b0;
        end else if (!mode) begin
            c_out       <= ws_res[W-1:0];
            c_valid_out <= prod_valid;
            if (prod_valid && ws_res[W]) ovf <= 1'b1;
        end else begin
            if (prod_valid) begin
                if (prod_clear) begin
                    acc <= prod;
                    ovf <= 1'b0;
                end else begin
                    acc <= os_res[W-1:0];
                    if (os_res[W]) ovf <= 1'b1;
                end
            end
            // acc_load drains the accumulator value from before this edge.
            if (acc_load) begin
                c_out       <= acc;
                c_valid_out <= 1'b1;
            end else begin
                c_out       <= c_in;
                c_valid_out <= c_valid_in;
            end
        end
    end

endmodule

// File: tb/tb_pe_dual_mode.sv
// tb_pe_dual_mode: directed-vector bench for pe_dual_mode.
// u_dut clamps on overflow (SATURATE=1). u_dut_wrap wraps (SATURATE=0).
// Both instances share the same inputs.
module tb_pe_dual_mode;

    localparam int unsigned AW = 8;
    localparam int unsigned BW = 8;
    localparam int unsigned W  = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          signed_en;
    logic [AW-1:0] a_in;
    logic          a_valid_in;
    logic          a_clear_in;
    logic [BW-1:0] b_path_in;
    logic          b_path_en_in;
    logic          b_en_in;
    logic [W-1:0]  c_in;
    logic          c_valid_in;
    logic          acc_load;

    logic [AW-1:0] a_out,        a_out_w;
    logic          a_valid_out,  a_valid_out_w;
    logic          a_clear_out,  a_clear_out_w;
    logic [BW-1:0] b_path_out,   b_path_out_w;
    logic          b_path_en_out, b_path_en_out_w;
    logic          b_en_out,     b_en_out_w;
    logic [W-1:0]  c_out,        c_out_w;
    logic          c_valid_out,  c_valid_out_w;
    logic          ovf,          ovf_w;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    pe_dual_mode #(.SATURATE(1)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .signed_en(signed_en),
        .a_in(a_in), .a_valid_in(a_valid_in), .a_clear_in(a_clear_in),
        .a_out(a_out), .a_valid_out(a_valid_out), .a_clear_out(a_clear_out),
        .b_path_in(b_path_in), .b_path_en_in(b_path_en_in), .b_en_in(b_en_in),
        .b_path_out(b_path_out), .b_path_en_out(b_path_en_out), .b_en_out(b_en_out),
        .c_in(c_in), .c_valid_in(c_valid_in), .acc_load(acc_load),
        .c_out(c_out), .c_valid_out(c_valid_out), .ovf(ovf)
    );

    pe_dual_mode #(.SATURATE(0)) u_dut_wrap (
        .clk(clk), .rst(rst), .mode(mode), .signed_en(signed_en),
        .a_in(a_in), .a_valid_in(a_valid_in), .a_clear_in(a_clear_in),
        .a_out(a_out_w), .a_valid_out(a_valid_out_w), .a_clear_out(a_clear_out_w),
        .b_path_in(b_path_in), .b_path_en_in(b_path_en_in), .b_en_in(b_en_in),
        .b_path_out(b_path_out_w), .b_path_en_out(b_path_en_out_w), .b_en_out(b_en_out_w),
        .c_in(c_in), .c_valid_in(c_valid_in), .acc_load(acc_load),
        .c_out(c_out_w), .c_valid_out(c_valid_out_w), .ovf(ovf_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [BW-1:0] w);
        b_path_in    = w;
        b_path_en_in = 1'b1;
        step();
        b_path_en_in = 1'b0;
        b_en_in      = 1'b1;
        step();
        b_en_in      = 1'b0;
    endtask

    // One WS transaction. On return, the third edge after a_in has passed.
    task automatic ws_op(input logic [AW-1:0] a, input logic [W-1:0] cin);
        a_in       = a;
        a_valid_in = 1'b1;
        step();
        a_valid_in = 1'b0;
        step();
        check("ws_no_early_valid", 32'(c_valid_out), 32'd0);
        c_in = cin;
        step();
    endtask

    // A single OS clear with a zero product. Resets acc and ovf.
    task automatic os_clear();
        mode       = 1'b1;
        a_in       = '0;
        a_valid_in = 1'b1;
        a_clear_in = 1'b1;
        step();
        a_valid_in = 1'b0;
        a_clear_in = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; signed_en = 1'b1;
        a_in = '0; a_valid_in = 1'b0; a_clear_in = 1'b0;
        b_path_in = '0; b_path_en_in = 1'b0; b_en_in = 1'b0;
        c_in = '0; c_valid_in = 1'b0; acc_load = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_c_out",       32'(c_out),       32'd0);
        check("rst_c_valid",     32'(c_valid_out), 32'd0);
        check("rst_ovf",         32'(ovf),         32'd0);
        check("rst_b_path_out",  32'(b_path_out),  32'd0);
        check("rst_a_valid_out", 32'(a_valid_out), 32'd0);

        // WS signed: -3 * 5 + 100 = 85, valid exactly three edges after a_in
        load_w(8'hFD);
        ws_op(8'd5, 20'd100);
        check("ws_signed_c_out", 32'(c_out),       32'd85);
        check("ws_signed_valid", 32'(c_valid_out), 32'd1);
        step();
        check("ws_valid_drops",  32'(c_valid_out), 32'd0);

        // Unsigned 255*255 vs signed (-1)*(-1)
        signed_en = 1'b0;
        load_w(8'hFF);
        ws_op(8'hFF, 20'd0);
        check("ws_unsigned_c_out", 32'(c_out), 32'd65025);
        check("ws_unsigned_ovf",   32'(ovf),   32'd0);
        signed_en = 1'b1;
        ws_op(8'hFF, 20'd0);
        check("ws_signed_m1_c_out", 32'(c_out), 32'd1);

        // Weight double buffer: active 2, shadow 7, then both enables with 9
        load_w(8'd2);
        b_path_in = 8'd7; b_path_en_in = 1'b1;
        step();
        b_path_in = 8'd9; b_en_in = 1'b1;
        step();
        b_path_en_in = 1'b0; b_en_in = 1'b0;
        check("dbuf_b_path_out",    32'(b_path_out),    32'd9);
        check("dbuf_b_path_en_out", 32'(b_path_en_out), 32'd1);
        check("dbuf_b_en_out",      32'(b_en_out),      32'd1);
        ws_op(8'd1, 20'd0);
        check("dbuf_active_is_old_shadow", 32'(c_out), 32'd7);

        // OS: 4 x (10*10), clear on the first = 400, then drain and shift
        load_w(8'd10);
        mode = 1'b1;
        a_in = 8'd10;
        for (int i = 0; i < 4; i++) begin
            a_valid_in = 1'b1;
            a_clear_in = (i == 0);
            step();
        end
        a_valid_in = 1'b0; a_clear_in = 1'b0;
        step(); step();
        acc_load = 1'b1;
        step();
        acc_load = 1'b0;
        check("os_drain_c_out", 32'(c_out),       32'd400);
        check("os_drain_valid", 32'(c_valid_out), 32'd1);
        c_in = 20'd123; c_valid_in = 1'b1;
        step();
        c_valid_in = 1'b0;
        check("os_shift_c_out", 32'(c_out),       32'd123);
        check("os_shift_valid", 32'(c_valid_out), 32'd1);
        step();
        check("os_shift_valid_drop", 32'(c_valid_out), 32'd0);
        check("os_ovf_clear", 32'(ovf), 32'd0);

        // Saturation at W=20: 524287 + 1
        mode = 1'b0;
        load_w(8'd1);
        ws_op(8'd1, 20'h7FFFF);
        check("sat_clamp_c_out", 32'(c_out),   32'h7FFFF);
        check("sat_clamp_ovf",   32'(ovf),     32'd1);
        check("sat_wrap_c_out",  32'(c_out_w), 32'h80000);
        check("sat_wrap_ovf",    32'(ovf_w),   32'd1);
        // ovf is sticky through a later non-overflowing sum
        ws_op(8'd1, 20'd0);
        check("sat_ovf_sticky",  32'(ovf),     32'd1);
        os_clear();
        check("sat_clear_ovf",      32'(ovf),   32'd0);
        check("sat_clear_ovf_wrap", 32'(ovf_w), 32'd0);

        // Reset mid-operation: set ovf again, then reset behind a valid a_in
        mode = 1'b0;
        ws_op(8'd1, 20'h7FFFF);
        check("pre_rst_ovf", 32'(ovf), 32'd1);
        a_in = 8'd5; a_valid_in = 1'b1; c_in = 20'd100;
        step();
        a_valid_in = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_c_out",      32'(c_out),       32'd0);
        check("mid_rst_c_valid",    32'(c_valid_out), 32'd0);
        check("mid_rst_ovf",        32'(ovf),         32'd0);
        check("mid_rst_a_out",      32'(a_out),       32'd0);
        check("mid_rst_b_path_out", 32'(b_path_out),  32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_no_stale", 32'(c_valid_out), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
